// File: rtl/key_scan_debounce.sv
// key_scan_debounce: samples a bank of push-buttons on a shared slow tick, debounces them and emits
// push/release/long/repeat pulses per key. Auto-repeat is built only when KEY_SCAN_REPEAT_EN is defined.
module key_scan_debounce #(
  parameter int KEY_N          = 5,
  parameter int SAMPLE_CYCLES  = 2000000,
  parameter int LONG_SAMPLES   = 50,
  parameter int REPEAT_SAMPLES = 10,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [KEY_N-1:0] key_in,
  output logic [KEY_N-1:0] key_state,
  output logic [KEY_N-1:0] key_push,
  output logic [KEY_N-1:0] key_release,
  output logic [KEY_N-1:0] key_long,
  output logic [KEY_N-1:0] key_repeat,
  output logic             sample_tick
);

  localparam int CNT_W  = $clog2(SAMPLE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_SAMPLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_SAMPLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_SAMPLES);
  localparam logic [KEY_N-1:0]  POLARITY  = (ACTIVE_LOW != 0) ? {KEY_N{1'b1}} : {KEY_N{1'b0}};

  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_LONG} key_st_e;

  logic [CNT_W-1:0]  cnt;
  logic              tick_d;
  logic [KEY_N-1:0]  sync1, sync2, samp, prev;
  key_st_e           st [KEY_N];
  logic [HOLD_W-1:0] hold_cnt [KEY_N];

`ifdef KEY_SCAN_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_SAMPLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_SAMPLES - 1);
  logic [RPT_W-1:0] rpt_cnt [KEY_N];
`else
  assign key_repeat = '0;
`endif

  assign sample_tick = (cnt == CNT_LAST);

  // Polarity is folded in ahead of the synchroniser so every register resets to "released".
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt    <= '0;
      tick_d <= 1'b0;
      sync1  <= '0;
      sync2  <= '0;
      samp   <= '0;
      prev   <= '0;
    end else begin
      sync1  <= key_in ^ POLARITY;
      sync2  <= sync1;
      cnt    <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      tick_d <= sample_tick;
      if (sample_tick) begin
        prev <= samp;
        samp <= sync2;
      end
    end
  end

  // Key FSMs step in the cycle after each sample edge, once samp/prev hold the two newest samples.
  always_ff @(posedge clk) begin
    if (clr) begin
      key_state   <= '0;
      key_push    <= '0;
      key_release <= '0;
      key_long    <= '0;
`ifdef KEY_SCAN_REPEAT_EN
      key_repeat  <= '0;
`endif
      for (int k = 0; k < KEY_N; k++) begin
        st[k]       <= ST_IDLE;
        hold_cnt[k] <= '0;
`ifdef KEY_SCAN_REPEAT_EN
        rpt_cnt[k]  <= '0;
`endif
      end
    end else begin
      key_push    <= '0;
      key_release <= '0;
      key_long    <= '0;
`ifdef KEY_SCAN_REPEAT_EN
      key_repeat  <= '0;
`endif
      if (tick_d) begin
        for (int k = 0; k < KEY_N; k++) begin
          case (st[k])
            ST_IDLE: begin
              if (samp[k] && prev[k]) begin
                st[k]        <= ST_PRESSED;
                key_state[k] <= 1'b1;
                key_push[k]  <= 1'b1;
                hold_cnt[k]  <= '0;
              end
            end
            ST_PRESSED: begin
              // Release is checked first so it wins over a long-press on the same tick.
              if (!samp[k] && !prev[k]) begin
                st[k]          <= ST_IDLE;
                key_state[k]   <= 1'b0;
                key_release[k] <= 1'b1;
              end else if (hold_cnt[k] == HOLD_LAST) begin
                st[k]       <= ST_LONG;
                key_long[k] <= 1'b1;
                hold_cnt[k] <= HOLD_MAX;
`ifdef KEY_SCAN_REPEAT_EN
                rpt_cnt[k]  <= '0;
`endif
              end else if (hold_cnt[k] != HOLD_MAX) begin
                hold_cnt[k] <= hold_cnt[k] + HOLD_W'(1);
              end
            end
            ST_LONG: begin
              if (!samp[k] && !prev[k]) begin
                st[k]          <= ST_IDLE;
                key_state[k]   <= 1'b0;
                key_release[k] <= 1'b1;
              end
`ifdef KEY_SCAN_REPEAT_EN
              else if (rpt_cnt[k] == RPT_LAST) begin
                key_repeat[k] <= 1'b1;
                rpt_cnt[k]    <= '0;
              end else begin
                rpt_cnt[k] <= rpt_cnt[k] + RPT_W'(1);
              end
`endif
            end
            default: st[k] <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule
